// File: rtl/div_pkg.sv
// Shared definitions for the decimal digit generator and its helpers.
package div_pkg;

  localparam int DIGIT_WIDTH = 4;
  localparam int RADIX       = 10;
  localparam int SUB_STEPS   = 4;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    SUB,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/div_mul10.sv
// Combinational multiply-by-ten using shift-add; output is 4 bits wider than input.
module div_mul10 #(
  parameter int IN_W = 16
) (
  input  logic [IN_W-1:0] a,
  output logic [IN_W+3:0] y
);

  logic [IN_W+3:0] a_ext;

  assign a_ext = {4'b0000, a};
  assign y     = (a_ext << 3) + (a_ext << 1);

endmodule

// File: rtl/div_digit_gen.sv
// Produces the first NUM_DIGITS decimal digits of num/den (num < den) by
// restoring division, writing one digit per strobe into a downstream RAM.
module div_digit_gen
  import div_pkg::*;
#(
  parameter int DEN_WIDTH  = 16,
  parameter int NUM_DIGITS = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic                  start,
  input  logic [DEN_WIDTH-1:0]  num,
  input  logic [DEN_WIDTH-1:0]  den,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int WIDE_W = DEN_WIDTH + 4;

  state_t state, next_state;

  logic [DEN_WIDTH-1:0]   den_q;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [DEN_WIDTH-1:0]   rem;
  logic [WIDE_W-1:0]      r10;
  logic [WIDE_W-1:0]      rem_x10;
  logic [WIDE_W-1:0]      den_sh;
  logic [DIGIT_WIDTH-1:0] q;
  logic [1:0]             k;
  logic [CNT_W-1:0]       d;
  logic                   bad_job;
  logic                   sub_ok;
  logic                   last_digit;

  div_mul10 #(.IN_W(DEN_WIDTH)) u_mul10 (
    .a (rem),
    .y (rem_x10)
  );

  // den == 0 is covered by num >= den, but is kept explicit for clarity.
  assign bad_job    = (den == '0) || (num >= den);
  assign den_sh     = {4'b0000, den_q} << k;
  assign sub_ok     = (r10 >= den_sh);
  assign last_digit = (d == CNT_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (!clear_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = bad_job ? DONE : MUL;
      MUL:     next_state = SUB;
      SUB:     if (k == 2'd0) next_state = WRITE;
      WRITE:   next_state = last_digit ? DONE : MUL;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      den_q   <= '0;
      base_q  <= '0;
      rem     <= '0;
      r10     <= '0;
      q       <= '0;
      k       <= '0;
      d       <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            den_q  <= den;
            base_q <= base_addr;
            rem    <= num;
            d      <= '0;
            busy   <= 1'b1;
            err    <= bad_job;
          end
        end
        MUL: begin
          r10 <= rem_x10;
          q   <= '0;
          k   <= 2'(SUB_STEPS - 1);
        end
        SUB: begin
          if (sub_ok) begin
            r10  <= r10 - den_sh;
            q[k] <= 1'b1;
          end
          k <= k - 2'd1;
        end
        WRITE: begin
          wr_en   <= 1'b1;
          wr_data <= q;
          wr_addr <= base_q + ADDR_WIDTH'(d);
          rem     <= r10[DEN_WIDTH-1:0];
          d       <= d + 1'b1;
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_digit_gen.sv
// Scoreboarded bench for div_digit_gen: expected writes are queued at job start
// and checked (address, digit, cycle) as the RAM strobes appear.
module tb_div_digit_gen;

  localparam int DW = 16;
  localparam int ND = 4;
  localparam int AW = 7;
  localparam int DTW = 4;

  logic          clk = 1'b0;
  logic          clear_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] num = '0;
  logic [DW-1:0] den = 16'd1;
  logic [AW-1:0] base_addr = '0;
  logic          busy, done, err, wr_en;
  logic [AW-1:0] wr_addr;
  logic [DTW-1:0] wr_data;

  div_digit_gen #(
    .DEN_WIDTH (DW),
    .NUM_DIGITS(ND),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DTW)
  ) dut (
    .clk      (clk),
    .clear_n  (clear_n),
    .start    (start),
    .num      (num),
    .den      (den),
    .base_addr(base_addr),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no++;

  typedef struct {
    logic [AW-1:0]  addr;
    logic [DTW-1:0] data;
    int             cyc;
  } exp_t;

  exp_t          sbq[$];
  int            total = 0;
  int            bad = 0;
  int            wr_count = 0;
  logic [DTW-1:0] ram [128];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (wr_en === 1'b1) begin
      wr_count++;
      ram[wr_addr] = wr_data;
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: got addr=%0d data=%0d cyc=%0d, wanted no write", wr_addr, wr_data, edge_no);
      end else begin
        e = sbq.pop_front();
        if ({wr_addr, wr_data} !== {e.addr, e.data} || edge_no != e.cyc) begin
          bad++;
          $display("FAIL wr_digit: got addr=%0d data=%0d cyc=%0d, wanted addr=%0d data=%0d cyc=%0d",
                   wr_addr, wr_data, edge_no, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic push_job(input int n, input int dd, input logic [AW-1:0] b, input int t0, input int cnt);
    int r;
    exp_t e;
    r = n;
    for (int i = 0; i < cnt; i++) begin
      r      = r * 10;
      e.addr = b + AW'(i);
      e.data = DTW'(r / dd);
      e.cyc  = t0 + 6 * (i + 1);
      sbq.push_back(e);
      r = r % dd;
    end
  endtask

  // Drives a one-cycle start; returns at the negedge after the accepting edge.
  task automatic start_job(input int n, input int dd, input logic [AW-1:0] b, input int cnt, output int t0);
    @(negedge clk);
    num = DW'(n); den = DW'(dd); base_addr = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = edge_no;
    num = DW'($urandom); den = DW'($urandom); base_addr = AW'($urandom);
    if (dd != 0 && n < dd) push_job(n, dd, b, t0, cnt);
  endtask

  task automatic wait_done(input int limit, output int dcyc, output bit ok, output logic derr);
    ok = 1'b0; dcyc = -1; derr = 1'bx;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dcyc = edge_no; derr = err; ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, err, wr_en, wr_addr, wr_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %b, wanted all zero", {busy, done, err, wr_en, wr_addr, wr_data});
    end
    clear_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, wanted 0 0", busy, done);
    end
  endtask

  task automatic test_third();
    int t0, dc, wc0; bit ok; logic de;
    wc0 = wr_count;
    start_job(1, 3, 7'd0, ND, t0);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL third_busy: got %b, wanted 1", busy); end
    wait_done(100, dc, ok, de);
    total++;
    if (!ok || dc != t0 + 6 * ND + 1) begin bad++; $display("FAIL third_done_cycle: got %0d, wanted %0d", dc, t0 + 6 * ND + 1); end
    total++;
    if (de !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL third_err_busy: got err=%b busy=%b, wanted 0 0", de, busy); end
    total++;
    if (wr_count - wc0 != ND) begin bad++; $display("FAIL third_writes: got %0d, wanted %0d", wr_count - wc0, ND); end
    for (int i = 0; i < ND; i++) begin
      total++;
      if (ram[i] !== 4'd3) begin bad++; $display("FAIL third_ram%0d: got %0d, wanted 3", i, ram[i]); end
    end
  endtask

  task automatic test_eighth();
    int t0, dc; bit ok; logic de;
    logic [DTW-1:0] want [4];
    want[0] = 4'd1; want[1] = 4'd2; want[2] = 4'd5; want[3] = 4'd0;
    start_job(1, 8, 7'd10, ND, t0);
    wait_done(100, dc, ok, de);
    total++;
    if (!ok || dc != t0 + 25 || de !== 1'b0) begin bad++; $display("FAIL eighth_done: got cyc=%0d err=%b, wanted cyc=%0d err=0", dc, de, t0 + 25); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ram[10 + i] !== want[i]) begin bad++; $display("FAIL eighth_ram%0d: got %0d, wanted %0d", 10 + i, ram[10 + i], want[i]); end
    end
  endtask

  task automatic test_wrap();
    int t0, dc; bit ok; logic de;
    start_job(999, 1000, 7'd126, ND, t0);
    wait_done(100, dc, ok, de);
    total++;
    if (!ok || dc != t0 + 25) begin bad++; $display("FAIL wrap_done: got %0d, wanted %0d", dc, t0 + 25); end
    total++;
    if ({ram[126], ram[127], ram[0], ram[1]} !== {4'd9, 4'd9, 4'd9, 4'd0}) begin
      bad++;
      $display("FAIL wrap_ram: got %0d %0d %0d %0d, wanted 9 9 9 0", ram[126], ram[127], ram[0], ram[1]);
    end
  endtask

  task automatic test_errors();
    int t0, dc, wc0; bit ok; logic de;
    int nums [2];
    int dens [2];
    nums[0] = 3; dens[0] = 0; nums[1] = 5; dens[1] = 5;
    for (int j = 0; j < 2; j++) begin
      wc0 = wr_count;
      start_job(nums[j], dens[j], 7'd50, ND, t0);
      wait_done(20, dc, ok, de);
      total++;
      if (!ok || dc != t0 + 1 || de !== 1'b1) begin bad++; $display("FAIL err_done%0d: got cyc=%0d err=%b, wanted cyc=%0d err=1", j, dc, de, t0 + 1); end
      repeat (3) @(negedge clk);
      total++;
      if (err !== 1'b1 || busy !== 1'b0 || wr_count != wc0) begin
        bad++;
        $display("FAIL err_hold%0d: got err=%b busy=%b writes=%0d, wanted 1 0 0", j, err, busy, wr_count - wc0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t0, dc, wc0; bit ok; logic de;
    wc0 = wr_count;
    start_job(1, 3, 7'd0, 1, t0);
    repeat (8) @(negedge clk);
    clear_n = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    wait_done(40, dc, ok, de);
    total++;
    if (ok) begin bad++; $display("FAIL abort_done: got done at %0d, wanted none", dc); end
    total++;
    if (wr_count - wc0 != 1 || sbq.size() != 0 || busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL abort_state: got writes=%0d pending=%0d busy=%b err=%b, wanted 1 0 0 0", wr_count - wc0, sbq.size(), busy, err);
    end
    start_job(1, 3, 7'd20, ND, t0);
    wait_done(100, dc, ok, de);
    total++;
    if (!ok || dc != t0 + 25 || de !== 1'b0) begin bad++; $display("FAIL restart_done: got cyc=%0d err=%b, wanted cyc=%0d err=0", dc, de, t0 + 25); end
    total++;
    if ({ram[20], ram[21], ram[22], ram[23]} !== {4'd3, 4'd3, 4'd3, 4'd3}) begin
      bad++;
      $display("FAIL restart_ram: got %0d %0d %0d %0d, wanted 3 3 3 3", ram[20], ram[21], ram[22], ram[23]);
    end
  endtask

  task automatic test_start_ignored();
    int t0, dc, wc0; bit ok; logic de;
    wc0 = wr_count;
    start_job(1, 7, 7'd40, ND, t0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100, dc, ok, de);
    total++;
    if (!ok || dc != t0 + 25) begin bad++; $display("FAIL ignore_done: got %0d, wanted %0d", dc, t0 + 25); end
    repeat (10) @(negedge clk);
    total++;
    if (wr_count - wc0 != ND || busy !== 1'b0) begin bad++; $display("FAIL ignore_writes: got %0d busy=%b, wanted %0d 0", wr_count - wc0, busy, ND); end
  endtask

  task automatic test_back_to_back();
    int t0, dc, wc0; bit ok; logic de;
    wc0 = wr_count;
    @(negedge clk);
    num = 16'd2; den = 16'd7; base_addr = 7'd60; start = 1'b1;
    @(negedge clk);
    t0 = edge_no;
    push_job(2, 7, 7'd60, t0, ND);
    push_job(2, 7, 7'd60, t0 + 26, ND);
    wait_done(100, dc, ok, de);
    total++;
    if (!ok || dc != t0 + 25) begin bad++; $display("FAIL b2b_first_done: got %0d, wanted %0d", dc, t0 + 25); end
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || edge_no != t0 + 26) begin bad++; $display("FAIL b2b_accept: got busy=%b at %0d, wanted 1 at %0d", busy, edge_no, t0 + 26); end
    start = 1'b0;
    wait_done(100, dc, ok, de);
    total++;
    if (!ok || dc != t0 + 51) begin bad++; $display("FAIL b2b_second_done: got %0d, wanted %0d", dc, t0 + 51); end
    total++;
    if (wr_count - wc0 != 2 * ND || sbq.size() != 0) begin
      bad++;
      $display("FAIL b2b_writes: got %0d pending=%0d, wanted %0d 0", wr_count - wc0, sbq.size(), 2 * ND);
    end
  endtask

  initial begin
    test_reset();
    test_third();
    test_eighth();
    test_wrap();
    test_errors();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    repeat (5) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d pending, wanted 0", sbq.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
